// File: rtl/bcd_pkg.sv
// Shared decimal-arithmetic package: digit geometry and sequencer states.
// Used by the serial BCD subtractor and the 3-digit BCD adder.
package bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_BASE = 10;
  localparam int NDIG     = 3;
  localparam int IDX_W    = $clog2(NDIG);

  typedef logic [DIGIT_W-1:0] digit_t;

  // Index 0 holds the least significant digit (digit 3).
  typedef logic [NDIG-1:0][DIGIT_W-1:0] bcd3_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_COMP,
    ST_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LSD = '0;
  localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(NDIG - 1);

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit step: d = a - b - bin, wrapped into 0..9 on borrow.
// Non-BCD digits run through the same formula, truncated to 4 bits.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W+1:0] w_diff;
  logic [DIGIT_W+1:0] w_adj;

  // Two guard bits: the MSB is the sign of a - b - bin (-16..15).
  always_comb begin
    w_diff = {2'b00, a} - {2'b00, b} - {{(DIGIT_W+1){1'b0}}, bin};
    w_adj  = w_diff + (DIGIT_W+2)'(BCD_BASE);
    bout   = w_diff[DIGIT_W+1];
    d      = bout ? w_adj[DIGIT_W-1:0] : w_diff[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_sub3_serial.sv
// Digit-serial 3-digit BCD subtractor, LSD first, start/busy/done handshake.
// Define BCD_SUB_MAG_EN for sign-magnitude output of negative results.
module bcd_sub3_serial
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIGIT_W-1:0] a1,
  input  logic [DIGIT_W-1:0] a2,
  input  logic [DIGIT_W-1:0] a3,
  input  logic [DIGIT_W-1:0] b1,
  input  logic [DIGIT_W-1:0] b2,
  input  logic [DIGIT_W-1:0] b3,
  input  logic               bi,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] d1,
  output logic [DIGIT_W-1:0] d2,
  output logic [DIGIT_W-1:0] d3,
  output logic               bo,
  output logic               neg
);

  state_t             r_state;
  state_t             w_nstate;
  bcd3_t              r_a;
  bcd3_t              r_b;
  bcd3_t              r_d;
  logic [IDX_W-1:0]   r_idx;
  logic               r_bin;
  logic               r_bo;
  logic               w_last;
  logic [DIGIT_W-1:0] w_opa;
  logic [DIGIT_W-1:0] w_opb;
  logic [DIGIT_W-1:0] w_d;
  logic               w_bout;
`ifdef BCD_SUB_MAG_EN
  logic               r_neg;
`endif

  assign w_last = (r_idx == IDX_MSD);

  // One digit unit, fed either the operands or 0 - result.
  always_comb begin
    w_opa = r_a[r_idx];
    w_opb = r_b[r_idx];
`ifdef BCD_SUB_MAG_EN
    if (r_state == ST_COMP) begin
      w_opa = '0;
      w_opb = r_d[r_idx];
    end
`endif
  end

  bcd_digit_sub u_dsub (
    .a    (w_opa),
    .b    (w_opb),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_nstate = ST_SUB;
      end
      ST_SUB: begin
        if (w_last) begin
`ifdef BCD_SUB_MAG_EN
          w_nstate = w_bout ? ST_COMP : ST_DONE;
`else
          w_nstate = ST_DONE;
`endif
        end
      end
      ST_COMP: begin
`ifdef BCD_SUB_MAG_EN
        if (w_last) w_nstate = ST_DONE;
`else
        w_nstate = ST_IDLE;
`endif
      end
      ST_DONE: begin
        w_nstate = ST_IDLE;
      end
      default: begin
        w_nstate = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_idx   <= IDX_LSD;
      r_bin   <= 1'b0;
      r_bo    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= {a1, a2, a3};
            r_b   <= {b1, b2, b3};
            r_bin <= bi;
            r_idx <= IDX_LSD;
            r_d   <= '0;
            r_bo  <= 1'b0;
          end
        end
        ST_SUB: begin
          r_d[r_idx] <= w_d;
          if (w_last) begin
            r_idx <= IDX_LSD;
            r_bin <= 1'b0;
            r_bo  <= w_bout;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_bin <= w_bout;
          end
        end
`ifdef BCD_SUB_MAG_EN
        ST_COMP: begin
          r_d[r_idx] <= w_d;
          if (w_last) begin
            r_idx <= IDX_LSD;
            r_bin <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_bin <= w_bout;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef BCD_SUB_MAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_neg <= 1'b0;
    end else if (r_state == ST_COMP && w_last) begin
      r_neg <= 1'b1;
    end
  end

  assign neg = r_neg;
`else
  assign neg = 1'b0;
`endif

  assign busy = (r_state == ST_SUB) || (r_state == ST_COMP);
  assign done = (r_state == ST_DONE);
  assign d1   = r_d[2];
  assign d2   = r_d[1];
  assign d3   = r_d[0];
  assign bo   = r_bo;

endmodule

// File: tb/tb_bcd_sub3_serial.sv
// Randomized bench for bcd_sub3_serial against an integer-arithmetic model.
// Honors BCD_SUB_MAG_EN the same way as the design.
module tb_bcd_sub3_serial;

`ifdef BCD_SUB_MAG_EN
  localparam bit MAG = 1'b1;
`else
  localparam bit MAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a1 = '0, a2 = '0, a3 = '0;
  logic [3:0] b1 = '0, b2 = '0, b3 = '0;
  logic       bi = 1'b0;
  logic       busy, done, bo, neg;
  logic [3:0] d1, d2, d3;

  bcd_sub3_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .b1    (b1),
    .b2    (b2),
    .b3    (b3),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .bo    (bo),
    .neg   (neg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;

  // Active operation: accepted at edge acc, done pulse after edge acc+lat.
  bit act = 1'b0;
  int acc = 0;
  int lat = 3;
  int x1, x2, x3, xbo, xneg;
  int h1 = 0, h2 = 0, h3 = 0, hbo = 0, hneg = 0;
  bit infl;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, e);
    end
  endtask

  task automatic lit(input string nm, input int e1, input int e2, input int e3,
                     input int ebo, input int eneg);
    chk({nm, " d1"}, d1, e1);
    chk({nm, " d2"}, d2, e2);
    chk({nm, " d3"}, d3, e3);
    chk({nm, " bo"}, bo, ebo);
    chk({nm, " neg"}, neg, eneg);
  endtask

  // Whole-number model: A - B - bi, then ten's complement or magnitude.
  task automatic set_model(input int p1, input int p2, input int p3,
                           input int q1, input int q2, input int q3,
                           input int pbi);
    int r, v;
    r = (p1 * 100 + p2 * 10 + p3) - (q1 * 100 + q2 * 10 + q3) - pbi;
    lat = 3;
    xneg = 0;
    xbo = (r < 0) ? 1 : 0;
    if (r >= 0) v = r;
    else if (MAG) begin
      v = -r;
      xneg = 1;
      lat = 6;
    end else v = r + 1000;
    x1 = (v / 100) % 10;
    x2 = (v / 10) % 10;
    x3 = v % 10;
  endtask

  initial forever begin
    @(posedge clk);
    e = e + 1;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      h1 = 0; h2 = 0; h3 = 0; hbo = 0; hneg = 0;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst d", {d1, d2, d3}, 0);
      chk("rst bo", bo, 0);
      chk("rst neg", neg, 0);
    end else begin
      infl = act && e >= acc && e <= acc + lat;
      chk("busy", busy, (act && e >= acc && e < acc + lat) ? 1 : 0);
      chk("done", done, (act && e == acc + lat) ? 1 : 0);
      if (act && e == acc + lat) begin
        lit("result", x1, x2, x3, xbo, xneg);
        h1 = x1; h2 = x2; h3 = x3; hbo = xbo; hneg = xneg;
      end else if (!infl) begin
        lit("hold", h1, h2, h3, hbo, hneg);
      end
    end
  end

  task automatic launch(input int p1, input int p2, input int p3,
                        input int q1, input int q2, input int q3,
                        input int pbi, input bit early, input bit spam);
    if (early) begin
      @(negedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
    end
    set_model(p1, p2, p3, q1, q2, q3, pbi);
    a1 = 4'(p1); a2 = 4'(p2); a3 = 4'(p3);
    b1 = 4'(q1); b2 = 4'(q2); b3 = 4'(q3);
    bi = pbi[0];
    start = 1'b1;
    acc = early ? e + 2 : e + 1;
    act = 1'b1;
    if (early) @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (spam) begin
      a1 = 4'd9; a2 = 4'd9; a3 = 4'd9;
      b1 = 4'd9; b2 = 4'd9; b3 = 4'd9;
      bi = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic finish_op();
    while (e < acc + lat) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input int p1, input int p2, input int p3,
                        input int q1, input int q2, input int q3,
                        input int pbi, input bit early);
    launch(p1, p2, p3, q1, q2, q3, pbi, early, 1'b0);
    finish_op();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("reset", 0, 0, 0, 0, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;

    run_op(4, 5, 6, 1, 2, 3, 0, 1'b0);
    lit("456-123", 3, 3, 3, 0, 0);
    run_op(1, 0, 0, 0, 0, 1, 0, 1'b0);
    lit("100-001", 0, 9, 9, 0, 0);
    run_op(1, 2, 3, 4, 5, 6, 0, 1'b0);
    lit("123-456", MAG ? 3 : 6, MAG ? 3 : 6, MAG ? 3 : 7, 1, MAG ? 1 : 0);
    run_op(0, 0, 0, 0, 0, 0, 1, 1'b0);
    lit("000-000-1", MAG ? 0 : 9, MAG ? 0 : 9, MAG ? 1 : 9, 1, MAG ? 1 : 0);

    launch(5, 0, 0, 0, 0, 1, 0, 1'b0, 1'b1);
    finish_op();
    lit("500-001 spam", 4, 9, 9, 0, 0);
    run_op(9, 9, 9, 9, 9, 9, 0, 1'b1);
    lit("999-999 b2b", 0, 0, 0, 0, 0);

    launch(9, 8, 7, 1, 2, 3, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    act = 1'b0;
    #1;
    lit("midrst", 0, 0, 0, 0, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    run_op(3, 2, 1, 0, 2, 1, 0, 1'b0);
    lit("321-021", 3, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      launch($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
             $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
             $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0));
      finish_op();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
